// File: rtl/clock_pkg.sv
// Shared constants for the digital clock front end: button FSM encoding and 50 MHz board timing.
// Pure declarations, no logic, no latency.
// No backpressure; consumers import what they need.
package clock_pkg;

    // Per-button FSM states; REPEATING is only reachable when auto-repeat is built in.
    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSED   = 2'd1,
        REPEATING = 2'd2
    } btn_state_t;

    // Default timing for the 50 MHz board.
    localparam int DEF_NUM_BTN         = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 1 s to first repeat
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;  // 200 ms between repeats

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, stable-time debouncer and press/auto-repeat FSM (auto-repeat with BTN_AUTOREPEAT_EN).
// level/pulse rise SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge sampling a clean press; all outputs registered.
// No backpressure: pulse is a fire-and-forget one-cycle strobe.
module btn_channel
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic level,
    output logic pulse,
    output logic held
);

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("btn_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("btn_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1 || HOLD_CYCLES < REPEAT_CYCLES) begin : g_chk_rep
        $error("btn_channel: need REPEAT_CYCLES >= 1 and HOLD_CYCLES >= REPEAT_CYCLES");
    end

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic [DW-1:0]          db_cnt;
    logic                   toggle;
    logic                   rise;
    logic                   fall;

    assign sync_out = sync[SYNC_STAGES-1];
    // The counter clears one step early so it never needs to hold DEBOUNCE_CYCLES itself.
    assign toggle   = (sync_out != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise     = toggle & ~level;
    assign fall     = toggle &  level;

    // Metastability synchroniser: shift the raw level through SYNC_STAGES flops.
    always_ff @(posedge CLK) begin
        if (!RST) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], btn};
    end

    // Debouncer: count consecutive cycles the synced input disagrees with level; flip level at terminal count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync_out == level) begin
            db_cnt <= '0;
        end else if (toggle) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    btn_state_t state;
    btn_state_t state_nxt;
    logic       pulse_nxt;

`ifdef BTN_AUTOREPEAT_EN
    // HOLD_CYCLES >= REPEAT_CYCLES, so one timer width covers both intervals.
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          held_nxt;

    // Next-state logic; a release always wins over a repeat due in the same cycle.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pulse_nxt = 1'b0;
        if (fall) begin
            state_nxt = RELEASED;
            timer_nxt = '0;
        end else begin
            case (state)
                RELEASED: begin
                    if (rise) begin
                        state_nxt = PRESSED;
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                    end
                end
                PRESSED: begin
                    if (timer == TW'(HOLD_CYCLES - 1)) begin
                        state_nxt = REPEATING;
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                REPEATING: begin
                    if (timer == TW'(REPEAT_CYCLES - 1)) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    timer_nxt = '0;
                end
            endcase
        end
        held_nxt = (state_nxt == REPEATING);
    end

    // State, timer and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= RELEASED;
            timer <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            pulse <= pulse_nxt;
            held  <= held_nxt;
        end
    end
`else
    // Next-state logic without auto-repeat: pulse only on the debounced rising edge.
    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        if (fall) begin
            state_nxt = RELEASED;
        end else if (state == RELEASED && rise) begin
            state_nxt = PRESSED;
            pulse_nxt = 1'b1;
        end
    end

    // State and registered pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= RELEASED;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            pulse <= pulse_nxt;
        end
    end

    assign held = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end (auto-repeat built in when BTN_AUTOREPEAT_EN is defined).
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from raw press to level/pulse; outputs registered in each channel.
// No backpressure; channels are independent and may all strobe in the same cycle.
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] pulse,
    output logic [NUM_BTN-1:0] held
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .CLK   (CLK),
            .RST   (RST),
            .btn   (btn[i]),
            .level (level[i]),
            .pulse (pulse[i]),
            .held  (held[i])
        );
    end

endmodule
